select_sequencer: RTL and testbench
===================================

# select_sequencer

Generates the 3-bit select code that drives the 3-to-8 decoder stage, stepping it through codes 0..7 at a programmable rate. Supports up, down, ping-pong and single-shot sweep modes with start/stop control and cycle-accurate status pulses. The block sits directly upstream of the decoder; its `s` output connects straight to the decoder's `s` input.

## Interface
- `DIV_WIDTH`, 16: width of the prescaler divisor and the prescaler counter.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  single-cycle request to begin or restart a sweep.
- `stop`  input  1  single-cycle request to halt the sweep.
- `mode`  input  2  sweep mode: 00 up, 01 down, 10 ping-pong, 11 single-shot up. Sampled only when `start` is accepted.
- `div`  input  DIV_WIDTH  dwell control: each code is held for `div`+1 cycles. Read live every cycle.
- `s`  output  3  select code to the decoder, registered.
- `busy`  output  1  high while in RUN.
- `tick`  output  1  one-cycle pulse, coincident with each new `s` value produced by a step.
- `wrap`  output  1  one-cycle pulse when a sweep cycle completes (defined per mode below).
- `done`  output  1  one-cycle pulse when a single-shot sweep ends.

## Operation
- Two states: IDLE and RUN. Internal registers:
  - prescaler count `pc` (DIV_WIDTH bits)
  - latched mode `m`
  - ping-pong direction bit `dir` (0 = up).
- Reset: state IDLE, `s`=0, `pc`=0, `dir`=0, `m`=00, `busy`/`tick`/`wrap`/`done`=0.
- IDLE:
  - `s` holds its last value.
  - On `start`, go to RUN and latch `m`=`mode`. Clear `pc` and set `dir`=0.
  - Load `s`=7 for down mode; otherwise load `s`=0.
- RUN:
  - Each cycle, if `pc` >= `div`, a step occurs and `pc` is set to 0. Otherwise `pc` increments.
  - The `>=` comparison makes a mid-run decrease of `div` take effect without waiting for a counter wrap.
- Step rules:
  - Up (00): `s`+1 modulo 8. The 7→0 step asserts `wrap`.
  - Down (01): `s`−1 modulo 8. The 0→7 step asserts `wrap`.
  - Ping-pong (10): sequence 0,1,…,7,6,…,1,0,1,… with no repeated endpoints.
    - `dir` flips on reaching 7 or 0.
    - The 1→0 step asserts `wrap`.
  - Single-shot (11): steps 0→7 like up mode. A step taken while `s`=7 leaves `s` at 7, asserts `done`, and returns to IDLE with `busy`=0. No `tick` or `wrap` on that step.
- Every step that changes `s` asserts `tick`.
- `stop` in RUN: next cycle goes to IDLE, `s` frozen at its current value, no pulses.
- `start` in RUN: restart exactly as from IDLE, relatching `mode`.
- `start` and `stop` in the same cycle: `stop` wins. `start` is ignored.
- `stop` in IDLE: no effect.
- `reset` has priority over everything, including mid-sweep. The block returns to its reset values on the next edge.

## Timing
- `start` is sampled at edge N. After N: `busy`=1 and `s` holds its initial code.
- With `div`=D and no interference, the first step lands at edge N+D+1. Each code is therefore visible for exactly D+1 cycles.
- `div`=0 steps every cycle. `s` and `tick` change at the same edge.
- `tick`, `wrap`, `done` are registered one-cycle pulses aligned with the step edge. All other edges hold them at 0.
- `busy` falls at the same edge that `done` rises, and at the edge following an accepted `stop`.
- Output latency from any control input to any output is one clock. There are no combinational paths from inputs to outputs.

## Test plan
- Reset, up mode:
  - Stimulus: `reset` high 2 cycles, then `mode`=00, `div`=0, `start` pulse.
  - Required: `s` = 0,1,…,7,0 on consecutive cycles; `tick` every cycle; `wrap` only with the 7→0 step; `busy`=1.
- Dwell, down mode:
  - Stimulus: `mode`=01, `div`=2, `start`.
  - Required: `s` starts at 7, each value held 3 cycles (7,7,7,6,6,6,…); `wrap` on 0→7; `tick` every 3rd cycle.
- Ping-pong:
  - Stimulus: `mode`=10, `div`=0, `start`; run 16 cycles.
  - Required: `s` = 0,1,2,3,4,5,6,7,6,5,4,3,2,1,0,1; single `wrap` at the 1→0 step.
- Single-shot:
  - Stimulus: `mode`=11, `div`=1.
  - Required: 0..7 each held 2 cycles; then `done` for 1 cycle, `busy`→0, `s` stays 7; no further `tick`.
- Stop/start interactions:
  - Stimulus: stop at `s`=4.
  - Required: IDLE next cycle with `s`=4 held.
  - Stimulus: `start`+`stop` in the same cycle.
  - Required: stays IDLE.
  - Stimulus: `start` during RUN in up mode at `s`=5 with `mode`=01.
  - Required: restart at 7 counting down.
- Mid-run changes:
  - Stimulus: `reset` mid-sweep at `s`=3.
  - Required: next edge `s`=0, `busy`=0, all pulses 0.
  - Stimulus: change `div` 10→1 while `pc`=6.
  - Required: step occurs on the next edge.

Source files
------------

// File: rtl/select_sequencer.sv
// -----------------------------------------------------------------------------
// select_sequencer
//
// Produces the 3-bit select code for the downstream 3-to-8 decoder. The code
// steps through 0..7 at a programmable dwell rate. Four sweep modes are
// supported: up, down, ping-pong and single-shot up. Start/stop control and
// one-cycle status pulses are provided, and every output is registered.
//
// Ports:
//   clk    - system clock, rising-edge active
//   reset  - synchronous active-high reset
//   start  - begin or restart a sweep; mode is latched here
//   stop   - halt the sweep (wins over a simultaneous start)
//   mode   - 00 up, 01 down, 10 ping-pong, 11 single-shot up
//   div    - each code is held for div+1 cycles; read live every cycle
//   s      - select code to the decoder
//   busy   - high while running
//   tick   - pulse with each new s value produced by a step
//   wrap   - pulse when a sweep cycle completes
//   done   - pulse when a single-shot sweep ends
// -----------------------------------------------------------------------------
module select_sequencer #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic [1:0]           mode,
  input  logic [DIV_WIDTH-1:0] div,
  output logic [2:0]           s,
  output logic                 busy,
  output logic                 tick,
  output logic                 wrap,
  output logic                 done
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;
  localparam logic [1:0] MODE_ONE  = 2'b11;

  localparam logic [DIV_WIDTH-1:0] PC_ZERO = {DIV_WIDTH{1'b0}};
  localparam logic [DIV_WIDTH-1:0] PC_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [2:0]           s_q, s_d;
  logic [DIV_WIDTH-1:0] pc_q, pc_d;
  logic [1:0]           m_q, m_d;
  logic                 dir_q, dir_d;
  logic                 busy_q, busy_d;
  logic                 tick_q, tick_d;
  logic                 wrap_q, wrap_d;
  logic                 done_q, done_d;

  // Next-state, step and status-pulse logic.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    pc_d    = pc_q;
    m_d     = m_q;
    dir_d   = dir_q;
    busy_d  = 1'b0;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    done_d  = 1'b0;

    if (stop) begin
      // stop beats start; in IDLE it simply changes nothing.
      if (state_q == ST_RUN) begin
        state_d = ST_IDLE;
      end else begin
        state_d = state_q;
      end
    end else if (start) begin
      // Fresh sweep from IDLE, or restart from RUN: identical behaviour.
      state_d = ST_RUN;
      m_d     = mode;
      pc_d    = PC_ZERO;
      dir_d   = 1'b0;
      if (mode == MODE_DOWN) begin
        s_d = 3'd7;
      end else begin
        s_d = 3'd0;
      end
    end else if (state_q == ST_RUN) begin
      // >= rather than == so that lowering div mid-dwell steps at once.
      if (pc_q >= div) begin
        pc_d = PC_ZERO;
        case (m_q)
          MODE_UP: begin
            s_d    = s_q + 3'd1;
            tick_d = 1'b1;
            if (s_q == 3'd7) begin
              wrap_d = 1'b1;
            end else begin
              wrap_d = 1'b0;
            end
          end
          MODE_DOWN: begin
            s_d    = s_q - 3'd1;
            tick_d = 1'b1;
            if (s_q == 3'd0) begin
              wrap_d = 1'b1;
            end else begin
              wrap_d = 1'b0;
            end
          end
          MODE_PP: begin
            tick_d = 1'b1;
            // Direction flips when the step lands on an endpoint, so the
            // endpoints are never shown twice in a row.
            if (dir_q == 1'b0) begin
              s_d = s_q + 3'd1;
              if (s_q == 3'd6) begin
                dir_d = 1'b1;
              end else begin
                dir_d = 1'b0;
              end
            end else begin
              s_d = s_q - 3'd1;
              if (s_q == 3'd1) begin
                dir_d  = 1'b0;
                wrap_d = 1'b1;
              end else begin
                dir_d  = 1'b1;
              end
            end
          end
          MODE_ONE: begin
            // A step from 7 ends the sweep without moving s.
            if (s_q == 3'd7) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              s_d    = s_q + 3'd1;
              tick_d = 1'b1;
            end
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end else begin
        pc_d = pc_q + PC_ONE;
      end
    end else begin
      state_d = state_q;
    end

    busy_d = (state_d == ST_RUN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      s_q     <= 3'd0;
      pc_q    <= PC_ZERO;
      m_q     <= 2'b00;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      pc_q    <= pc_d;
      m_q     <= m_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign s    = s_q;
  assign busy = busy_q;
  assign tick = tick_q;
  assign wrap = wrap_q;
  assign done = done_q;

endmodule

// File: tb/tb_select_sequencer.sv
// -----------------------------------------------------------------------------
// tb_select_sequencer
//
// Directed stimulus for select_sequencer. Each driven cycle pushes the
// hand-derived output vector {s, busy, tick, wrap, done} expected after the
// following rising edge. An independent monitor pops and compares one entry
// per cycle.
// -----------------------------------------------------------------------------
module tb_select_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic [1:0]  mode;
  logic [15:0] div;
  logic [2:0]  s;
  logic        busy;
  logic        tick;
  logic        wrap;
  logic        done;

  logic [6:0]  exp_q[$];
  string       name_q[$];
  int          checks;
  int          errors;
  logic [15:0] cur_div;

  select_sequencer #(.DIV_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .stop  (stop),
    .mode  (mode),
    .div   (div),
    .s     (s),
    .busy  (busy),
    .tick  (tick),
    .wrap  (wrap),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare one expected vector per cycle, just after the edge.
  always @(posedge clk) begin
    logic [6:0] e;
    logic [6:0] a;
    string      n;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {s, busy, tick, wrap, done};
      checks = checks + 1;
      if (a !== e) begin
        errors = errors + 1;
        $display("FAIL %s: got s=%0d busy=%b tick=%b wrap=%b done=%b, expected s=%0d busy=%b tick=%b wrap=%b done=%b",
                 n, a[6:4], a[3], a[2], a[1], a[0], e[6:4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  // Drive one cycle of inputs and record the expected post-edge outputs.
  task automatic cyc(input logic rs, input logic st, input logic sp,
                     input logic [1:0] md, input logic [15:0] dv,
                     input int es, input logic eb, input logic et,
                     input logic ew, input logic ed, input string nm);
    logic [2:0] es3;
    @(negedge clk);
    reset = rs;
    start = st;
    stop  = sp;
    mode  = md;
    div   = dv;
    es3   = es[2:0];
    exp_q.push_back({es3, eb, et, ew, ed});
    name_q.push_back(nm);
  endtask

  // Plain running cycle; mode is driven to a non-latched value on purpose.
  task automatic nx(input int es, input logic eb, input logic et,
                    input logic ew, input logic ed, input string nm);
    cyc(1'b0, 1'b0, 1'b0, 2'b10, cur_div, es, eb, et, ew, ed, nm);
  endtask

  int pp[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    start   = 1'b0;
    stop    = 1'b0;
    mode    = 2'b00;
    div     = 16'd0;
    cur_div = 16'd0;

    // Reset held two cycles.
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 16'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "reset0");
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 16'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "reset1");

    // Up mode, div=0: 0,1,..,7,0 with wrap only on 7->0.
    cur_div = 16'd0;
    cyc(1'b0, 1'b1, 1'b0, 2'b00, cur_div, 0, 1'b1, 1'b0, 1'b0, 1'b0, "up_start");
    for (int i = 1; i <= 8; i++) begin
      nx(i % 8, 1'b1, 1'b1, (i == 8), 1'b0, "up_step");
    end
    // Continue to s=4, then stop.
    for (int i = 1; i <= 4; i++) begin
      nx(i, 1'b1, 1'b1, 1'b0, 1'b0, "up_to4");
    end
    cyc(1'b0, 1'b0, 1'b1, 2'b10, cur_div, 4, 1'b0, 1'b0, 1'b0, 1'b0, "stop_at4");
    nx(4, 1'b0, 1'b0, 1'b0, 1'b0, "idle_hold4");
    cyc(1'b0, 1'b1, 1'b1, 2'b00, cur_div, 4, 1'b0, 1'b0, 1'b0, 1'b0, "start_stop_same");
    nx(4, 1'b0, 1'b0, 1'b0, 1'b0, "still_idle");
    cyc(1'b0, 1'b0, 1'b1, 2'b00, cur_div, 4, 1'b0, 1'b0, 1'b0, 1'b0, "stop_in_idle");

    // Down mode, div=2: each code held 3 cycles, wrap on 0->7.
    cur_div = 16'd2;
    cyc(1'b0, 1'b1, 1'b0, 2'b01, cur_div, 7, 1'b1, 1'b0, 1'b0, 1'b0, "down_start");
    for (int j = 1; j <= 24; j++) begin
      nx((7 - j / 3) & 7, 1'b1, (j % 3 == 0), (j == 24), 1'b0, "down_dwell");
    end
    cyc(1'b0, 1'b0, 1'b1, 2'b10, cur_div, 7, 1'b0, 1'b0, 1'b0, 1'b0, "down_stop");

    // Ping-pong, div=0: 16 codes, single wrap on 1->0.
    cur_div = 16'd0;
    cyc(1'b0, 1'b1, 1'b0, 2'b10, cur_div, 0, 1'b1, 1'b0, 1'b0, 1'b0, "pp_start");
    for (int i = 1; i <= 15; i++) begin
      nx(pp[i], 1'b1, 1'b1, (i == 14), 1'b0, "pp_step");
    end
    cyc(1'b0, 1'b0, 1'b1, 2'b10, cur_div, 1, 1'b0, 1'b0, 1'b0, 1'b0, "pp_stop");

    // Single-shot, div=1: 0..7 two cycles each, then done and back to idle.
    cur_div = 16'd1;
    cyc(1'b0, 1'b1, 1'b0, 2'b11, cur_div, 0, 1'b1, 1'b0, 1'b0, 1'b0, "ss_start");
    for (int j = 1; j <= 15; j++) begin
      nx((j / 2 > 7) ? 7 : j / 2, 1'b1, (j % 2 == 0), 1'b0, 1'b0, "ss_step");
    end
    nx(7, 1'b0, 1'b0, 1'b0, 1'b1, "ss_done");
    nx(7, 1'b0, 1'b0, 1'b0, 1'b0, "ss_after0");
    nx(7, 1'b0, 1'b0, 1'b0, 1'b0, "ss_after1");

    // Restart during an up sweep at s=5 with mode=down.
    cur_div = 16'd0;
    cyc(1'b0, 1'b1, 1'b0, 2'b00, cur_div, 0, 1'b1, 1'b0, 1'b0, 1'b0, "rs_start_up");
    for (int i = 1; i <= 5; i++) begin
      nx(i, 1'b1, 1'b1, 1'b0, 1'b0, "rs_up");
    end
    cyc(1'b0, 1'b1, 1'b0, 2'b01, cur_div, 7, 1'b1, 1'b0, 1'b0, 1'b0, "restart_down");
    for (int i = 1; i <= 4; i++) begin
      nx(7 - i, 1'b1, 1'b1, 1'b0, 1'b0, "rs_down");
    end

    // Reset mid-sweep at s=3.
    cyc(1'b1, 1'b0, 1'b0, 2'b10, cur_div, 0, 1'b0, 1'b0, 1'b0, 1'b0, "mid_reset");
    nx(0, 1'b0, 1'b0, 1'b0, 1'b0, "post_reset_idle");

    // div lowered 10 -> 1 while pc=6: step on the very next edge.
    cur_div = 16'd10;
    cyc(1'b0, 1'b1, 1'b0, 2'b00, cur_div, 0, 1'b1, 1'b0, 1'b0, 1'b0, "div_start");
    for (int i = 1; i <= 6; i++) begin
      nx(0, 1'b1, 1'b0, 1'b0, 1'b0, "div_wait");
    end
    cur_div = 16'd1;
    nx(1, 1'b1, 1'b1, 1'b0, 1'b0, "div_drop_step");
    nx(1, 1'b1, 1'b0, 1'b0, 1'b0, "div1_hold");
    nx(2, 1'b1, 1'b1, 1'b0, 1'b0, "div1_step");
    cyc(1'b0, 1'b0, 1'b1, 2'b10, cur_div, 2, 1'b0, 1'b0, 1'b0, 1'b0, "final_stop");

    // Let the monitor drain the queue, bounded.
    for (int k = 0; k < 10; k++) begin
      if (exp_q.size() > 0) begin
        @(posedge clk);
        #2;
      end
    end
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
